// File: rtl/sudoku_ctrl_pkg.sv
// Shared types and widths for the sudoku solver sequencing controller.
// Optional stall detection is enabled by defining SUDOKU_STALL_DETECT_EN.
package sudoku_ctrl_pkg;

  localparam int CYC_W = 8;
  localparam int CNT_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    REPORT,
    DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ST_NONE,
    ST_SOLVED,
    ST_FAIL,
    ST_STUCK
  } status_t;

endpackage

// File: rtl/cell_popcount.sv
// Combinational population count of the solver's per-cell decided mask.
// Used only when SUDOKU_STALL_DETECT_EN is defined.
module cell_popcount
  import sudoku_ctrl_pkg::*;
#(
  parameter int CELLS = 81
) (
  input  logic [CELLS-1:0] mask,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < CELLS; i++) begin
      count = count + CNT_W'(mask[i]);
    end
  end

endmodule

// File: rtl/sudoku_solve_ctrl.sv
// Launches the solver, watches for termination and hands off to the output streamer.
// Define SUDOKU_STALL_DETECT_EN to end runs that stop making progress.
module sudoku_solve_ctrl
  import sudoku_ctrl_pkg::*;
#(
  parameter int CELLS        = 81,
  parameter int STALL_CYCLES = 4,
  parameter int MAX_CYCLES   = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_done,
  output logic             solver_start,
  input  logic             solver_done,
  input  logic             solver_fail,
  input  logic [CELLS-1:0] solved_mask,
  output logic             out_req,
  input  logic             out_done,
  output logic             ready,
  output logic             busy,
  output logic [1:0]       status,
  output logic [CYC_W-1:0] cycles,
  output logic             overrun
);

  state_t           state;
  state_t           state_nxt;
  status_t          stat_q;
  status_t          term_stat;
  logic             pending;
  logic             term;
  logic             timeout;
  logic             stall_hit;
  logic [CYC_W-1:0] cyc_nxt;

  assign status = stat_q;

  assign cyc_nxt = (cycles == CYC_W'(MAX_CYCLES))
                 ? cycles : cycles + 1'b1;
  assign timeout = (cyc_nxt == CYC_W'(MAX_CYCLES));

`ifdef SUDOKU_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] prev_cnt;
  logic             prev_valid;
  logic [SW-1:0]    stall_cnt;
  logic             same;

  cell_popcount #(
    .CELLS(CELLS)
  ) u_pop (
    .mask (solved_mask),
    .count(cnt)
  );

  // First RUN cycle only captures; no progress compare yet.
  assign same      = prev_valid && (cnt == prev_cnt);
  assign stall_hit = same && (stall_cnt >= SW'(STALL_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_cnt   <= '0;
      prev_valid <= 1'b0;
      stall_cnt  <= '0;
    end else if (state == START) begin
      prev_valid <= 1'b0;
      stall_cnt  <= '0;
    end else if (state == RUN) begin
      prev_cnt   <= cnt;
      prev_valid <= 1'b1;
      stall_cnt  <= same ? stall_cnt + 1'b1 : '0;
    end
  end
`else
  logic mask_unused;

  assign stall_hit   = 1'b0;
  assign mask_unused = ^solved_mask ^ STALL_CYCLES[0];
`endif

  always_comb begin
    term      = 1'b1;
    term_stat = ST_STUCK;
    if (solver_fail) begin
      term_stat = ST_FAIL;
    end else if (solver_done) begin
      term_stat = ST_SOLVED;
    end else if (!(stall_hit || timeout)) begin
      term = 1'b0;
    end
    if (state != RUN) begin
      term = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (load_done || pending) begin
          state_nxt = START;
        end
      end
      START:  state_nxt = RUN;
      RUN: begin
        if (term) begin
          state_nxt = REPORT;
        end
      end
      REPORT: state_nxt = DRAIN;
      DRAIN: begin
        if (out_done) begin
          state_nxt = pending ? START : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    solver_start = 1'b0;
    out_req      = 1'b0;
    busy         = 1'b1;
    ready        = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        busy  = 1'b0;
        ready = !pending;
      end
      (state == START):  solver_start = 1'b1;
      (state == REPORT): out_req = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_q  <= ST_NONE;
      cycles  <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (state == START) begin
        cycles <= '0;
      end else if (state == RUN) begin
        cycles <= cyc_nxt;
        if (term) begin
          stat_q <= term_stat;
        end
      end
      // A second load while one is queued is lost.
      if (state == IDLE) begin
        if (pending) begin
          pending <= load_done;
        end
      end else begin
        if (state == DRAIN && out_done && pending) begin
          pending <= 1'b0;
        end
        if (load_done) begin
          if (pending) begin
            overrun <= 1'b1;
          end else begin
            pending <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sudoku_solve_ctrl.sv
// Randomized scoreboard bench for sudoku_solve_ctrl.
// Follows SUDOKU_STALL_DETECT_EN to pick the expected stall behaviour.
module tb_sudoku_solve_ctrl;

`ifdef SUDOKU_STALL_DETECT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        load_done;
  logic        solver_start;
  logic        solver_done;
  logic        solver_fail;
  logic [80:0] solved_mask;
  logic        out_req;
  logic        out_done;
  logic        ready;
  logic        busy;
  logic [1:0]  status;
  logic [7:0]  cycles;
  logic        overrun;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int st;
    int cy;
  } exp_t;

  exp_t sb[$];
  int   cnt_seq[256];
  bit   exp_overrun;

  sudoku_solve_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .load_done   (load_done),
    .solver_start(solver_start),
    .solver_done (solver_done),
    .solver_fail (solver_fail),
    .solved_mask (solved_mask),
    .out_req     (out_req),
    .out_done    (out_done),
    .ready       (ready),
    .busy        (busy),
    .status      (status),
    .cycles      (cycles),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Mask with exactly n bits set, rotated to a random position.
  function automatic logic [80:0] mk_mask(input int n);
    logic [80:0] m;
    int r;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    r = $urandom_range(0, 80);
    if (r != 0) m = (m << r) | (m >> (81 - r));
    return m;
  endfunction

  task automatic gen_seq(input int mode);
    int c;
    c = $urandom_range(0, 30);
    for (int k = 1; k <= 255; k++) begin
      case (mode)
        0: cnt_seq[k] = (k < 81) ? k : 81;
        1: cnt_seq[k] = 40;
        default: begin
          if (c < 81 && $urandom_range(0, 1) == 1) c++;
          cnt_seq[k] = c;
        end
      endcase
    end
  endtask

  // Reference: first event in order fail, done, 4 repeated counts, budget.
  task automatic ref_run(input int fail_at, input int done_at,
                         output int st, output int cy);
    int same_run;
    same_run = 0;
    st = 3;
    cy = 255;
    for (int k = 1; k <= 255; k++) begin
      if (k > 1 && cnt_seq[k] == cnt_seq[k-1]) same_run++;
      else same_run = 0;
      if (k == fail_at) begin st = 2; cy = k; return; end
      if (k == done_at) begin st = 1; cy = k; return; end
      if (STALL_EN && same_run >= 4) begin st = 3; cy = k; return; end
    end
  endtask

  task automatic do_run(input bit kick, input int fail_at, input int done_at,
                        input int mode, input int loads, input bit drain_load);
    int st;
    int cy;
    exp_t e;
    gen_seq(mode);
    ref_run(fail_at, done_at, st, cy);
    e.st = st;
    e.cy = cy;
    sb.push_back(e);
    if (kick) begin
      load_done = 1'b1;
      @(negedge clk);
      load_done = 1'b0;
      check("start_latency", solver_start, 1);
    end
    for (int k = 1; k <= cy; k++) begin
      @(negedge clk);
      solved_mask = mk_mask(cnt_seq[k]);
      solver_fail = (k == fail_at);
      solver_done = (k == done_at);
      load_done   = (loads >= 1 && k == 2) || (loads >= 2 && k == 4);
    end
    @(negedge clk);
    solver_fail = 1'b0;
    solver_done = 1'b0;
    load_done   = 1'b0;
    check("out_req_latency", out_req, 1);
    if (loads >= 2) exp_overrun = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    out_done  = 1'b1;
    load_done = drain_load;
    @(negedge clk);
    out_done  = 1'b0;
    load_done = 1'b0;
    check("status_hold", status, st);
    check("overrun", overrun, exp_overrun);
    if (loads >= 1) begin
      check("queued_start", solver_start, 1);
      check("queued_not_ready", ready, 0);
    end else if (drain_load) begin
      check("drain_load_idle_busy", busy, 0);
      check("drain_load_ready", ready, 0);
      @(negedge clk);
      check("drain_load_start", solver_start, 1);
    end else begin
      check("idle_ready", ready, 1);
      check("idle_busy", busy, 0);
      check("cycles_hold", cycles, cy);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_status"}, status, 0);
    check({tag, "_cycles"}, cycles, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, solver_start, 0);
    check({tag, "_out_req"}, out_req, 0);
  endtask

  // Monitor: every out_req pulse is matched against the scoreboard.
  initial begin
    bit prev_req;
    bit prev_ss;
    exp_t e;
    prev_req = 1'b0;
    prev_ss  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
        prev_ss  = 1'b0;
      end else begin
        if (solver_start) check("start_pulse_width", prev_ss, 0);
        if (out_req) begin
          if (prev_req) begin
            check("out_req_pulse_width", prev_req, 0);
          end else if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out_req: got pulse, want none");
          end else begin
            e = sb.pop_front();
            check("status", status, e.st);
            check("cycles", cycles, e.cy);
          end
        end
        prev_req = out_req;
        prev_ss  = solver_start;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fa;
    int da;
    reset       = 1'b1;
    load_done   = 1'b0;
    solver_done = 1'b0;
    solver_fail = 1'b0;
    solved_mask = '0;
    out_done    = 1'b0;
    exp_overrun = 1'b0;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_run(1, 0, 10, 0, 0, 0);
    do_run(1, 3, 3, 0, 0, 0);
    do_run(1, 0, 0, 1, 0, 0);
    do_run(1, 0, 0, 0, 0, 0);
    do_run(1, 0, 12, 2, 1, 0);
    do_run(0, 0, 7, 0, 0, 0);
    do_run(1, 0, 12, 0, 2, 0);
    do_run(0, 0, 8, 0, 0, 0);
    do_run(1, 0, 6, 0, 0, 1);
    do_run(0, 5, 0, 0, 0, 0);

    // Abort a run on its sixth cycle.
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      solved_mask = mk_mask(k);
    end
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("midrun_reset");
    @(negedge clk);
    reset       = 1'b0;
    solved_mask = '0;
    exp_overrun = 1'b0;
    @(negedge clk);
    do_run(1, 0, 9, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      fa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
      da = ($urandom_range(0, 2) != 0) ? $urandom_range(1, 60) : 0;
      do_run(1, fa, da, $urandom_range(0, 2), 0, 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
